// File: rtl/fft_stage_ctrl_if.sv
// Bank-side control bundle of the in-place radix-4 FFT pass sequencer.
// slave is the sequencer; master is the loader/SRAM/butterfly side.
interface fft_stage_ctrl_if #(
  parameter int AddrWidth = 4,
  parameter int NumStages = AddrWidth / 2 + 1
);
  localparam int SW = (NumStages > 1) ? $clog2(NumStages) : 1;

  logic                       start_fft_i;
  logic                       ren_o;
  logic [3:0][AddrWidth-1:0]  rd_addr_o;
  logic [AddrWidth-1:0]       tw_idx_o;
  logic [SW-1:0]              stage_o;
  logic [3:0]                 wen_o;
  logic [3:0][AddrWidth-1:0]  wr_addr_o;
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output start_fft_i,
    input  ren_o,
    input  rd_addr_o,
    input  tw_idx_o,
    input  stage_o,
    input  wen_o,
    input  wr_addr_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_fft_i,
    output ren_o,
    output rd_addr_o,
    output tw_idx_o,
    output stage_o,
    output wen_o,
    output wr_addr_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// In-place radix-4 pass sequencer: reads all four banks per slot,
// drives twiddle index, writes back after the butterfly latency.
module fft_stage_ctrl #(
  parameter int AddrWidth   = 4,
  parameter int NumStages   = AddrWidth / 2 + 1,
  parameter int BflyLatency = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fft_stage_ctrl_if.slave bus
);
  localparam int AW = AddrWidth;
  localparam int L  = BflyLatency;
  localparam int SW = (NumStages > 1) ? $clog2(NumStages) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [SW-1:0]   s_q, s_d;

  logic            ren_q, ren_d;
  logic [AW-1:0]   ra_q, ra_d;
  logic [AW-1:0]   tw_q, tw_d;
  logic [SW-1:0]   stage_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*AW-1:0] rot;

  logic [L:1]          dl_vld;
  logic [L:1][AW-1:0]  dl_adr;
  logic [L:0]          pend;
  logic                last_wr;
  logic                k_last;
  logic                s_last;

  // The pass is fully written back when only the oldest slot is still live.
  always_comb begin
    pend    = {dl_vld, ren_q};
    last_wr = pend[L] & ~(|pend[L-1:0]);
    k_last  = (k_q == '1);
    s_last  = (s_q == SW'(NumStages - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start_fft_i) begin
          state_d = READ;
          k_d     = '0;
          s_d     = '0;
        end
      end
      (state_q == READ): begin
        if (k_last) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      (state_q == DRAIN): begin
        if (last_wr) begin
          if (!s_last) begin
            state_d = READ;
            k_d     = '0;
            s_d     = s_q + 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      (state_q == DONE): begin
        state_d = IDLE;
        k_d     = '0;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they land registered
  // in the same cycle the FSM enters it.
  always_comb begin
    rot    = {k_d, k_d} << {s_d, 1'b0};
    ren_d  = (state_d == READ);
    ra_d   = '0;
    tw_d   = '0;
    if (ren_d) begin
      ra_d = rot[2*AW-1:AW];
      tw_d = k_d << {s_d, 1'b0};
    end
    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ren_q   <= 1'b0;
      ra_q    <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ren_q   <= ren_d;
      ra_q    <= ra_d;
      tw_q    <= tw_d;
      stage_q <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_vld <= '0;
      dl_adr <= '0;
    end else begin
      dl_vld[1] <= ren_q;
      dl_adr[1] <= ra_q;
      for (int i = 2; i <= L; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_adr[i] <= dl_adr[i-1];
      end
    end
  end

  assign bus.ren_o     = ren_q;
  assign bus.rd_addr_o = {4{ra_q}};
  assign bus.tw_idx_o  = tw_q;
  assign bus.stage_o   = stage_q;
  assign bus.wen_o     = {4{dl_vld[L]}};
  assign bus.wr_addr_o = {4{dl_adr[L]}};
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: default config plus a
// small AddrWidth=2 / BflyLatency=1 instance.
module tb_fft_stage_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  fft_stage_ctrl_if #(.AddrWidth(4), .NumStages(3)) bus ();
  fft_stage_ctrl_if #(.AddrWidth(2), .NumStages(2)) sbus ();

  fft_stage_ctrl #(
    .AddrWidth(4), .NumStages(3), .BflyLatency(4)
  ) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  fft_stage_ctrl #(
    .AddrWidth(2), .NumStages(2), .BflyLatency(1)
  ) u_small (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (sbus)
  );

  typedef struct {
    int cyc;
    int ra;
    int tw;
    int st;
  } vec_t;

  vec_t tbl[10];
  bit   starts[0:199];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int c,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", nm, c, act, exp);
    end
  endtask

  function automatic bit in_rd(int r, int d, int l, int s);
    for (int p = 0; p < s; p++)
      if (r >= 1 + p * (d + l) && r <= d + p * (d + l)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_wr(int r, int d, int l, int s);
    return in_rd(r - l, d, l, s);
  endfunction

  function automatic bit in_busy(int r, int d, int l, int s);
    return (r >= 1) && (r <= s * (d + l));
  endfunction

  function automatic bit is_done(int r, int d, int l, int s);
    return r == s * (d + l) + 1;
  endfunction

  task automatic run_main(input int ncyc, input int b1);
    bit er, ew, eb, ed;
    for (int c = 0; c < ncyc; c++) begin
      er = in_rd(c, 16, 4, 3);
      ew = in_wr(c, 16, 4, 3);
      eb = in_busy(c, 16, 4, 3);
      ed = is_done(c, 16, 4, 3);
      if (b1 >= 0) begin
        er |= in_rd(c - b1, 16, 4, 3);
        ew |= in_wr(c - b1, 16, 4, 3);
        eb |= in_busy(c - b1, 16, 4, 3);
        ed |= is_done(c - b1, 16, 4, 3);
      end
      chk("ren", c, int'(bus.ren_o), int'(er));
      chk("wen", c, int'(bus.wen_o), ew ? 15 : 0);
      chk("busy", c, int'(bus.busy_o), int'(eb));
      chk("done", c, int'(bus.done_o), int'(ed));
      if (c >= 41 && c <= 56) chk("tw_last_pass", c, int'(bus.tw_idx_o), 0);
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          chk("rd_addr0", c, int'(bus.rd_addr_o[0]), tbl[i].ra);
          chk("rd_addr3", c, int'(bus.rd_addr_o[3]), tbl[i].ra);
          chk("tw_idx", c, int'(bus.tw_idx_o), tbl[i].tw);
          chk("stage", c, int'(bus.stage_o), tbl[i].st);
        end
        if (tbl[i].cyc + 4 == c) begin
          chk("wr_addr0", c, int'(bus.wr_addr_o[0]), tbl[i].ra);
          chk("wr_addr2", c, int'(bus.wr_addr_o[2]), tbl[i].ra);
        end
      end
      bus.start_fft_i = starts[c];
      @(negedge clk_i);
    end
    bus.start_fft_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm, input int c);
    chk({nm, "_ren"}, c, int'(bus.ren_o), 0);
    chk({nm, "_wen"}, c, int'(bus.wen_o), 0);
    chk({nm, "_busy"}, c, int'(bus.busy_o), 0);
    chk({nm, "_done"}, c, int'(bus.done_o), 0);
    chk({nm, "_stage"}, c, int'(bus.stage_o), 0);
    chk({nm, "_rd_addr"}, c, int'(bus.rd_addr_o), 0);
    chk({nm, "_wr_addr"}, c, int'(bus.wr_addr_o), 0);
    chk({nm, "_tw"}, c, int'(bus.tw_idx_o), 0);
  endtask

  initial begin
    tbl[0] = '{cyc: 1,  ra: 0,  tw: 0,  st: 0};
    tbl[1] = '{cyc: 6,  ra: 5,  tw: 5,  st: 0};
    tbl[2] = '{cyc: 16, ra: 15, tw: 15, st: 0};
    tbl[3] = '{cyc: 21, ra: 0,  tw: 0,  st: 1};
    tbl[4] = '{cyc: 22, ra: 4,  tw: 4,  st: 1};
    tbl[5] = '{cyc: 27, ra: 9,  tw: 8,  st: 1};
    tbl[6] = '{cyc: 34, ra: 7,  tw: 4,  st: 1};
    tbl[7] = '{cyc: 41, ra: 0,  tw: 0,  st: 2};
    tbl[8] = '{cyc: 47, ra: 6,  tw: 0,  st: 2};
    tbl[9] = '{cyc: 56, ra: 15, tw: 0,  st: 2};

    rst_ni            = 1'b0;
    bus.start_fft_i   = 1'b1;
    sbus.start_fft_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset", -1);
    bus.start_fft_i = 1'b0;
    rst_ni          = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_ren", -1, int'(bus.ren_o), 0);
    chk("idle_busy", -1, int'(bus.busy_o), 0);

    // single run
    foreach (starts[i]) starts[i] = 1'b0;
    starts[0] = 1'b1;
    run_main(70, -1);

    // ignored starts, then a restart right after done
    starts[10] = 1'b1;
    starts[30] = 1'b1;
    starts[61] = 1'b1;
    starts[62] = 1'b1;
    run_main(130, 62);

    // asynchronous reset in the middle of pass 1
    for (int c = 0; c < 23; c++) begin
      bus.start_fft_i = (c == 0);
      @(negedge clk_i);
    end
    chk("pre_rst_ren", 23, int'(bus.ren_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_rst", 23);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("post_rst_wen", c, int'(bus.wen_o), 0);
      chk("post_rst_ren", c, int'(bus.ren_o), 0);
      @(negedge clk_i);
    end
    foreach (starts[i]) starts[i] = 1'b0;
    starts[0] = 1'b1;
    run_main(70, -1);

    // small configuration: D=4, L=1, S=2
    for (int c = 0; c < 16; c++) begin
      chk("s_ren", c, int'(sbus.ren_o), int'(in_rd(c, 4, 1, 2)));
      chk("s_wen", c, int'(sbus.wen_o), in_wr(c, 4, 1, 2) ? 15 : 0);
      chk("s_busy", c, int'(sbus.busy_o), int'(in_busy(c, 4, 1, 2)));
      chk("s_done", c, int'(sbus.done_o), int'(is_done(c, 4, 1, 2)));
      if (c == 4) begin
        chk("s_rd_addr", c, int'(sbus.rd_addr_o[1]), 3);
        chk("s_tw", c, int'(sbus.tw_idx_o), 3);
      end
      if (c == 5) chk("s_wr_addr", c, int'(sbus.wr_addr_o[1]), 3);
      if (c == 7) begin
        chk("s_rd_addr_p1", c, int'(sbus.rd_addr_o[0]), 1);
        chk("s_tw_p1", c, int'(sbus.tw_idx_o), 0);
        chk("s_stage_p1", c, int'(sbus.stage_o), 1);
      end
      sbus.start_fft_i = (c == 0);
      @(negedge clk_i);
    end
    sbus.start_fft_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Control block that sits directly downstream of the stage-1 loader address generator in the FFT pipeline. After the loader has filled the four SRAM banks and pulsed its start-FFT flag, this block runs every radix-4 pass in place. Each pass reads the same slot from all four banks, hands the twiddle index to the butterfly, and writes the results back after a fixed butterfly latency. It drains between passes to avoid read-after-write hazards, and pulses done when the final pass has been written back.

## Interface
- AddrWidth, 4: bank address width. Must be even. Bank depth D = 2^AddrWidth; transform size N = 4·D.
- NumStages, AddrWidth/2+1: number of radix-4 passes (3 at default).
- BflyLatency, 4: cycles from a bank read to the matching write-back (SRAM read plus butterfly). Must be ≥1.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_fft_i  in  1  single-cycle pulse from the loader; starts the pass sequence
- ren_o  out  1  read enable, common to all 4 banks
- rd_addr_o  out  4×AddrWidth  read address per bank
- tw_idx_o  out  AddrWidth  twiddle exponent for the butterfly; valid while ren_o=1
- stage_o  out  $clog2(NumStages)  current pass index
- wen_o  out  4  write enables, one per bank
- wr_addr_o  out  4×AddrWidth  write-back address per bank
- busy_o  out  1  high from the first read through the last write-back
- done_o  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_fft_i=1 → READ with k=0, s=0.
  - start_fft_i is ignored in every other state.
- READ:
  - Issue one read per cycle for k = 0..D-1.
  - rd_addr_o[b] = rotl(k, 2s) over AddrWidth bits, identical for all banks b.
  - tw_idx_o = (k << 2s) truncated to AddrWidth. This is 0 for every k on the last pass.
  - After k=D-1 → DRAIN.
- DRAIN:
  - Wait until the last write of the pass has been issued.
  - If s < NumStages-1: s ← s+1 → READ, k=0.
  - Otherwise → DONE.
- DONE: assert done_o for one cycle, then → IDLE.
- Write-back path:
  - A BflyLatency-deep shift register carries {valid, rd_addr}.
  - When the delayed valid is set: wen_o = 4'b1111 and wr_addr_o = delayed rd_addr. Otherwise wen_o = 4'b0000.
- Counters:
  - k is AddrWidth bits and is not allowed to wrap within a pass.
  - s saturates at NumStages-1.
- Reset mid-operation: the FSM, the counters and the whole delay line clear immediately. No stale write-backs are emitted after reset release.

## Timing
- All outputs are registered. Every output resets to 0 and the FSM resets to IDLE.
- Cycle 0: start_fft_i sampled high in IDLE.
- Cycle 1: first read (ren_o=1, k=0, s=0).
- Pass s reads in cycles 1+s·(D+BflyLatency) through D+s·(D+BflyLatency).
- The write for the read in cycle t occurs in cycle t+BflyLatency.
- The next pass begins its first read the cycle after the previous pass's last write. Reads and writes of different passes never overlap.
- busy_o is high from cycle 1 through the final write cycle.
- done_o pulses the cycle after the final write. A start_fft_i in that cycle is ignored; the FSM re-enters IDLE and can accept a start the following cycle.
- Defaults (D=16, L=4, S=3):
  - Reads in cycles 1–16, 21–36 and 41–56.
  - Final write in cycle 60.
  - done_o in cycle 61.
- stage_o updates in the same cycle as the first read of each pass.

## Test plan
- Reset then idle: all outputs 0. A start_fft_i asserted while rst_ni=0 is ignored.
- Single run, defaults: start in cycle 0 → ren_o high in cycles 1–16, 21–36 and 41–56; wen_o=4'b1111 in cycles 5–20, 25–40 and 45–60; done_o only in cycle 61; busy_o high in cycles 1–60.
- Address and twiddle check, pass 1 with k=6: rd_addr_o = 4'b1001 (9) and tw_idx_o = 8. Four cycles later, wr_addr_o = 9 with wen_o=4'b1111. On pass 2, tw_idx_o = 0 for all k.
- Start pulses in cycles 10, 30 and 61 are ignored; timing is identical to the single run. A start in cycle 62 launches a new run with its first read in cycle 63.
- rst_ni dropped in cycle 23: outputs clear asynchronously. No wen_o pulses occur after release, and a fresh start reproduces the single-run timing.
- Parameter sweep with AddrWidth=2 and BflyLatency=1: 2 passes, reads in cycles 1–4 and 6–9, done_o in cycle 11.
